fifo_read_streamer: RTL and testbench

//  Read-side consumer for the asynchronous FIFO, in the r_clk domain. Drives the FIFO pop

---
 rtl/fifo_rd_pkg.sv | 18 +
 rtl/fifo_read_streamer_if.sv | 16 +
 rtl/rd_skid_buf.sv | 72 +++++++
 rtl/fifo_read_streamer.sv | 101 ++++++++++
 tb/tb_fifo_read_streamer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fifo_rd_pkg : shared types and constants for the FIFO read streamer   |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
package fifo_rd_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int RD_LATENCY = 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

endpackage
`default_nettype wire

// File: rtl/fifo_read_streamer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fifo_read_streamer_if : valid/ready word stream                       |
// | Revision              : 1.0                                           |
// +-----------------------------------------------------------------------+
interface fifo_read_streamer_if #(
    parameter int DATA_SIZE = 8
);
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_SIZE-1:0] m_data;

    modport master (output m_valid, output m_data, input  m_ready);
    modport slave  (input  m_valid, input  m_data, output m_ready);
endinterface
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rd_skid_buf : 2-entry in-order register FIFO absorbing read latency   |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 clr,
    input  wire logic                 wr,
    input  wire logic [DATA_SIZE-1:0] din,
    input  wire logic                 rd,
    output logic      [DATA_SIZE-1:0] dout,
    output logic      [1:0]           occupancy
);

    logic [DATA_SIZE-1:0] mem_q [SKID_DEPTH];
    logic [DATA_SIZE-1:0] mem_d [SKID_DEPTH];
    logic [1:0]           occ_q;
    logic [1:0]           occ_d;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        mem_d = mem_q;
        occ_d = occ_q;
        if (clr) begin
            occ_d = 2'd0;
        end else begin
            case ({wr, rd})
                2'b10: begin
                    mem_d[occ_q[0]] = din;
                    occ_d           = occ_q + 2'd1;
                end
                2'b01: begin
                    mem_d[0] = mem_q[1];
                    occ_d    = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        mem_d[0] = din;
                    end else begin
                        mem_d[0] = mem_q[1];
                        mem_d[1] = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            occ_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign dout      = (occ_q != 2'd0) ? mem_q[0] : '0;
    assign occupancy = occ_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr && !rd && !clr && occ_q == 2'd2));

endmodule
`default_nettype wire

// File: rtl/fifo_read_streamer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fifo_read_streamer : pops an async FIFO and presents a valid/ready    |
// |                      stream with word and read-error counters         |
// | Revision           : 1.0                                              |
// +-----------------------------------------------------------------------+
module fifo_read_streamer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int CNT_W     = 16
) (
    input  wire logic                 r_clk,
    input  wire logic                 rrst_n,
    input  wire logic                 enable,
    input  wire logic                 flush,
    input  wire logic                 fifo_empty,
    output logic                      fifo_r_en,
    input  wire logic [DATA_SIZE-1:0] fifo_rdata,
    input  wire logic                 fifo_rd_err,
    fifo_read_streamer_if.master      m,
    output logic                      busy,
    output logic      [CNT_W-1:0]     word_count,
    output logic      [CNT_W-1:0]     err_count
);

    logic [1:0]            state_q, state_d;
    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0]      word_count_q, word_count_d;
    logic [CNT_W-1:0]      err_count_q, err_count_d;

    logic [1:0]            occ;
    logic [1:0]            pending;
    logic                  xfer;
    logic                  skid_wr;
    logic [DATA_SIZE-1:0]  skid_dout;

    assign xfer = (occ != 2'd0) && m.m_ready;

    // Credit counts the head leaving this cycle so a full pipe still pops every cycle.
    assign pending   = occ + 2'(inflight_q) - 2'(xfer);
    assign fifo_r_en = (state_q == ST_RUN) && !fifo_empty && !flush && (pending < 2'd2);
    assign skid_wr   = inflight_q[0] && !fifo_rd_err && !flush;

    rd_skid_buf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .clk       (r_clk),
        .rst_n     (rrst_n),
        .clr       (flush),
        .wr        (skid_wr),
        .din       (fifo_rdata),
        .rd        (xfer),
        .dout      (skid_dout),
        .occupancy (occ)
    );

    always_comb begin
        state_d      = state_q;
        inflight_d   = fifo_r_en;
        word_count_d = word_count_q + CNT_W'(xfer);
        err_count_d  = err_count_q;
        if (inflight_q[0] && fifo_rd_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (occ == 2'd0 && !inflight_q[0]) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q      <= ST_IDLE;
            inflight_q   <= '0;
            word_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign m.m_valid  = (occ != 2'd0);
    assign m.m_data   = skid_dout;
    assign busy       = (state_q != ST_IDLE);
    assign word_count = word_count_q;
    assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_streamer.sv
`default_nettype none
// Bench for fifo_read_streamer: behavioural FIFO source, scoreboard on the stream side.
module tb_fifo_read_streamer;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          r_clk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd_err = 1'b0;
    logic          busy;
    logic [CW-1:0] word_count;
    logic [CW-1:0] err_count;

    fifo_read_streamer_if #(.DATA_SIZE(DW)) m_if ();

    fifo_read_streamer #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
        .r_clk       (r_clk),
        .rrst_n      (rrst_n),
        .enable      (enable),
        .flush       (flush),
        .fifo_empty  (fifo_empty),
        .fifo_r_en   (fifo_r_en),
        .fifo_rdata  (fifo_rdata),
        .fifo_rd_err (fifo_rd_err),
        .m           (m_if.master),
        .busy        (busy),
        .word_count  (word_count),
        .err_count   (err_count)
    );

    always #5 r_clk = ~r_clk;

    int errors = 0;
    int checks = 0;

    // Source FIFO model: registered read, one cycle after the pop strobe.
    logic [8:0] mem [0:2047];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge r_clk) begin
        if (fifo_r_en) begin
            fifo_rdata  <= mem[rd_ptr % 2048][7:0];
            fifo_rd_err <= mem[rd_ptr % 2048][8];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    logic [DW-1:0] sb [$];
    int            n_xfer = 0;
    logic [CW-1:0] exp_wc = '0;

    task automatic push(input logic [7:0] d, input logic err);
        mem[wr_ptr % 2048] = {err, d};
        wr_ptr++;
        if (!err) sb.push_back(d);
    endtask

    always @(negedge r_clk) begin
        if (rrst_n && m_if.m_valid && m_if.m_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stream_data: got %h, expected no word", m_if.m_data);
            end else begin
                logic [DW-1:0] e;
                e = sb.pop_front();
                if (m_if.m_data !== e) begin
                    errors++;
                    $display("FAIL stream_data: got %h, expected %h", m_if.m_data, e);
                end
            end
            n_xfer++;
            exp_wc = exp_wc + 8'd1;
        end
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cycles, output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (fifo_empty && !m_if.m_valid && !fifo_r_en) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        enable = 1'b0;
        m_if.m_ready = 1'b0;
        push(8'h11, 1'b0);
        tick();
        tick();
        checks++;
        if (fifo_r_en !== 1'b0 || m_if.m_valid !== 1'b0 || m_if.m_data !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: r_en=%b valid=%b data=%h busy=%b, expected 0/0/00/0",
                     fifo_r_en, m_if.m_valid, m_if.m_data, busy);
        end
        checks++;
        if (word_count !== 8'd0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: wc=%0d ec=%0d, expected 0/0", word_count, err_count);
        end
        rrst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fifo_r_en !== 1'b0 || m_if.m_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: r_en=%b valid=%b busy=%b, expected 0/0/0",
                         fifo_r_en, m_if.m_valid, busy);
            end
        end
        enable = 1'b1;
        #1;
        checks++;
        if (fifo_r_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_pop: r_en=%b, expected 0", fifo_r_en);
        end
        tick();
        checks++;
        if (fifo_r_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_first_pop: r_en=%b busy=%b, expected 1/1", fifo_r_en, busy);
        end
        tick();
        checks++;
        if (m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid=%b, expected 0", m_if.m_valid);
        end
        tick();
        checks++;
        if (m_if.m_valid !== 1'b1 || m_if.m_data !== 8'h11) begin
            errors++;
            $display("FAIL latency_first: valid=%b data=%h, expected 1/11", m_if.m_valid, m_if.m_data);
        end
        m_if.m_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (word_count !== 8'd1) begin
            errors++;
            $display("FAIL first_count: wc=%0d, expected 1", word_count);
        end
    endtask

    task automatic test_stream();
        logic [CW-1:0] wc0;
        int k = 0;
        wc0 = exp_wc;
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i), 1'b0);
        while (!m_if.m_valid && k < 6) begin
            tick();
            k++;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m_if.m_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_gap: cycle %0d valid=%b, expected 1", i, m_if.m_valid);
            end
            tick();
        end
        checks++;
        if (word_count !== wc0 + 8'd8 || word_count !== exp_wc) begin
            errors++;
            $display("FAIL stream_count: wc=%0d, expected %0d", word_count, wc0 + 8'd8);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fifo_r_en !== 1'b0 || m_if.m_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_no_pop: r_en=%b valid=%b, expected 0/0", fifo_r_en, m_if.m_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int pop0, x0, k;
        logic [DW-1:0] held;
        bit ok;
        pop0 = rd_ptr;
        x0 = n_xfer;
        k = 0;
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i), 1'b0);
        while (!m_if.m_valid && k < 6) begin
            tick();
            k++;
        end
        tick();
        tick();
        m_if.m_ready = 1'b0;
        held = m_if.m_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== held) begin
                errors++;
                $display("FAIL bp_hold: valid=%b data=%h, expected 1/%h", m_if.m_valid, m_if.m_data, held);
            end
        end
        checks++;
        if ((rd_ptr - pop0) - (n_xfer - x0) != 2 || fifo_r_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_outstanding: outstanding=%0d r_en=%b, expected 2/0",
                     (rd_ptr - pop0) - (n_xfer - x0), fifo_r_en);
        end
        m_if.m_ready = 1'b1;
        wait_drain(100, ok);
        checks++;
        if (!ok || sb.size() != 0 || n_xfer - x0 != 8) begin
            errors++;
            $display("FAIL bp_release: drained=%0d left=%0d words=%0d, expected 1/0/8",
                     ok, sb.size(), n_xfer - x0);
        end
    endtask

    task automatic test_rd_err();
        logic [CW-1:0] ec0;
        bit ok;
        ec0 = err_count;
        push(8'hC0, 1'b0);
        push(8'hFF, 1'b1);
        push(8'hC1, 1'b0);
        wait_drain(100, ok);
        checks++;
        if (!ok || err_count !== ec0 + 8'd1 || sb.size() != 0) begin
            errors++;
            $display("FAIL rd_err_drop: drained=%0d ec=%0d left=%0d, expected 1/%0d/0",
                     ok, err_count, sb.size(), ec0 + 8'd1);
        end
        for (int i = 0; i < 300; i++) push(8'hFF, 1'b1);
        wait_drain(1000, ok);
        checks++;
        if (!ok || err_count !== 8'hFF) begin
            errors++;
            $display("FAIL err_saturate: drained=%0d ec=%0d, expected 1/255", ok, err_count);
        end
        push(8'hFF, 1'b1);
        push(8'hC2, 1'b0);
        push(8'hFF, 1'b1);
        wait_drain(100, ok);
        checks++;
        if (!ok || err_count !== 8'hFF || sb.size() != 0) begin
            errors++;
            $display("FAIL err_stays_sat: ec=%0d left=%0d, expected 255/0", err_count, sb.size());
        end
    endtask

    task automatic test_enable_off();
        int pop0, x0;
        bit ok;
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) tick();
        enable = 1'b0;
        tick();
        pop0 = rd_ptr;
        x0 = n_xfer;
        checks++;
        if (fifo_r_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_state: r_en=%b busy=%b, expected 0/1", fifo_r_en, busy);
        end
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (rd_ptr != pop0 || n_xfer - x0 != 2 || busy !== 1'b0 || m_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: pops=%0d words=%0d busy=%b valid=%b, expected 0/2/0/0",
                     rd_ptr - pop0, n_xfer - x0, busy, m_if.m_valid);
        end
        enable = 1'b1;
        wait_drain(100, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++;
            $display("FAIL reenable: drained=%0d left=%0d, expected 1/0", ok, sb.size());
        end
    endtask

    task automatic test_flush();
        logic [CW-1:0] wc0;
        logic [DW-1:0] dropped;
        bit ok;
        m_if.m_ready = 1'b0;
        push(8'hE0, 1'b0);
        push(8'hE1, 1'b0);
        push(8'hE2, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        wc0 = word_count;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dropped = sb.pop_front();
        dropped = sb.pop_front();
        checks++;
        if (m_if.m_valid !== 1'b0 || word_count !== wc0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_buffered: valid=%b wc=%0d busy=%b, expected 0/%0d/1",
                     m_if.m_valid, word_count, busy, wc0);
        end
        tick();
        flush = 1'b1;
        dropped = sb.pop_front();
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_if.m_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_inflight: valid=%b data=%h, expected 0", m_if.m_valid, m_if.m_data);
            end
            tick();
        end
        m_if.m_ready = 1'b1;
        push(8'hF0, 1'b0);
        wait_drain(100, ok);
        checks++;
        if (!ok || sb.size() != 0 || word_count !== wc0 + 8'd1) begin
            errors++;
            $display("FAIL flush_after: left=%0d wc=%0d, expected 0/%0d", sb.size(), word_count, wc0 + 8'd1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        m_if.m_ready = 1'b0;
        push(8'h51, 1'b0);
        push(8'h52, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (m_if.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: valid=%b, expected 1", m_if.m_valid);
        end
        rrst_n = 1'b0;
        #1;
        checks++;
        if (m_if.m_valid !== 1'b0 || word_count !== 8'd0 || err_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b wc=%0d ec=%0d busy=%b, expected 0/0/0/0",
                     m_if.m_valid, word_count, err_count, busy);
        end
        sb.delete();
        exp_wc = '0;
        tick();
        rrst_n = 1'b1;
        m_if.m_ready = 1'b1;
        push(8'h53, 1'b0);
        wait_drain(100, ok);
        checks++;
        if (!ok || sb.size() != 0 || word_count !== 8'd1) begin
            errors++;
            $display("FAIL post_reset: left=%0d wc=%0d, expected 0/1", sb.size(), word_count);
        end
    endtask

    initial begin
        m_if.m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_rd_err();
        test_enable_off();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
